// File: rtl/temperature_calc_pipe.sv
// temperature_calc_pipe: multi-channel pipelined temperature calculator.
// tempc = tc_base[ch] + tc_ref[ch] * adc_data, saturated to OUT_W bits.
// Calibration is held per channel; results leave in acceptance order.
// Optional TC_AVG_EN adds a per-channel moving-average stage (latency 3).
module temperature_calc_pipe #(
  parameter int ADC_W  = 16,
  parameter int REF_W  = 8,
  parameter int BASE_W = 32,
  parameter int OUT_W  = 32,
  parameter int NCH    = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [BASE_W-1:0] cfg_base,
  input  logic [REF_W-1:0]  cfg_ref,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [ADC_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_tempc,
  output logic              out_ovf
);

  localparam int PROD_W = ADC_W + REF_W;
  localparam int SUM_W  = OUT_W + 1;

  logic [BASE_W-1:0] tc_base [NCH];
  logic [REF_W-1:0]  tc_ref  [NCH];

  logic              adv;
  logic              ch_ok;
  logic [BASE_W-1:0] sel_base;
  logic [REF_W-1:0]  sel_ref;

  logic              s1_valid;
  logic [PROD_W-1:0] s1_prod;
  logic [BASE_W-1:0] s1_base;
  logic [CH_W-1:0]   s1_ch;

  logic [SUM_W-1:0]  sum_full;
  logic              sat_ovf;
  logic [OUT_W-1:0]  sat_val;

  // The whole pipeline moves as one; a held output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Calibration lookup for the incoming sample; out-of-range channels match nothing.
  always_comb begin
    sel_base = '0;
    sel_ref  = '0;
    ch_ok    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if ({1'b0, in_ch} == (CH_W+1)'(i)) begin
        sel_base = tc_base[i];
        sel_ref  = tc_ref[i];
        ch_ok    = 1'b1;
      end
    end
  end

  // Calibration registers; a same-cycle sample already read the old values above.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        tc_base[i] <= '0;
        tc_ref[i]  <= REF_W'(1);
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NCH; i++) begin
        if ({1'b0, cfg_ch} == (CH_W+1)'(i)) begin
          tc_base[i] <= cfg_base;
          tc_ref[i]  <= cfg_ref;
        end
      end
    end
  end

  // Stage 1: multiply; samples for nonexistent channels become bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_base  <= '0;
      s1_ch    <= '0;
    end else if (adv) begin
      s1_valid <= in_valid && ch_ok;
      if (in_valid && ch_ok) begin
        s1_prod <= PROD_W'(in_data) * PROD_W'(sel_ref);
        s1_base <= sel_base;
        s1_ch   <= in_ch;
      end
    end
  end

  // One extra bit of headroom exposes overflow for saturation.
  always_comb begin
    sum_full = SUM_W'(s1_base) + SUM_W'(s1_prod);
    sat_ovf  = sum_full[OUT_W];
    sat_val  = sat_ovf ? '1 : sum_full[OUT_W-1:0];
  end

`ifdef TC_AVG_EN
  logic              s2_valid;
  logic [OUT_W-1:0]  s2_val;
  logic              s2_ovf;
  logic [CH_W-1:0]   s2_ch;
  logic [OUT_W-1:0]  avg_q    [NCH];
  logic              avg_seen [NCH];
  logic [OUT_W-1:0]  cur_avg;
  logic              cur_seen;
  logic signed [SUM_W-1:0] diff;
  logic signed [SUM_W-1:0] step;
  logic [OUT_W-1:0]  new_avg;

  // Stage 2: saturated raw sum waiting for the averager.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_val   <= '0;
      s2_ovf   <= 1'b0;
      s2_ch    <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_val <= sat_val;
        s2_ovf <= sat_ovf;
        s2_ch  <= s1_ch;
      end
    end
  end

  // EMA step: avg += (sum - avg) >>> 2; first sample of a channel seeds avg.
  always_comb begin
    cur_avg  = '0;
    cur_seen = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if ({1'b0, s2_ch} == (CH_W+1)'(i)) begin
        cur_avg  = avg_q[i];
        cur_seen = avg_seen[i];
      end
    end
    diff    = $signed({1'b0, s2_val}) - $signed({1'b0, cur_avg});
    step    = diff >>> 2;
    new_avg = cur_seen ? (cur_avg + step[OUT_W-1:0]) : s2_val;
  end

  // Stage 3: output register plus per-channel average state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_tempc <= '0;
      out_ovf   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        avg_q[i]    <= '0;
        avg_seen[i] <= 1'b0;
      end
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_ch    <= s2_ch;
        out_tempc <= new_avg;
        out_ovf   <= s2_ovf;
        for (int i = 0; i < NCH; i++) begin
          if ({1'b0, s2_ch} == (CH_W+1)'(i)) begin
            avg_q[i]    <= new_avg;
            avg_seen[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  // Stage 2: output register holding the saturated sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_tempc <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch    <= s1_ch;
        out_tempc <= sat_val;
        out_ovf   <= sat_ovf;
      end
    end
  end
`endif

endmodule
